// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multicycle control FSM for a small RV32I-style datapath:
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with TRAP on illegal opcodes.
//
// Optional feature macro: MC_PERF_CNT_EN (adds CycleCnt / InstRet counters and ports).
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   Opcode    in   [6:0] instruction opcode, sampled in DECODE only
//   BrTaken   in   branch-compare result (PC source is muxed outside this block)
//   MemReady  in   memory done strobe (fetch, load and store)
//   IFetch    out  instruction fetch request (FETCH)
//   IRWrite   out  instruction register load (FETCH with MemReady)
//   PCWrite   out  PC update strobe
//   ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, JSel, JalrSel, RWSel
//             out  datapath controls
//   ALUOp     out  [1:0] ALU operation class
//   State     out  [2:0] current state code
//   Illegal   out  sticky trap flag
//   CycleCnt  out  [31:0] cycle counter        (MC_PERF_CNT_EN only)
//   InstRet   out  [31:0] retired-instr counter (MC_PERF_CNT_EN only)

module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] Opcode,
   input  logic       BrTaken,
   input  logic       MemReady,
   output logic       IFetch,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       ALUSrc,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       Branch,
   output logic       JSel,
   output logic       JalrSel,
   output logic       RWSel,
   output logic [1:0] ALUOp,
   output logic [2:0] State,
   output logic       Illegal
`ifdef MC_PERF_CNT_EN
   ,
   output logic [31:0] CycleCnt,
   output logic [31:0] InstRet
`endif
);

   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [6:0] opc_q, opc_d;
   logic       illegal_q;

   // Branch outcome only steers the external PC mux.
   logic unused_brtaken;
   assign unused_brtaken = BrTaken;

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_I, OP_R, OP_LUI, OP_LW, OP_SW, OP_BR, OP_JALR, OP_JAL: is_legal = 1'b1;
         default:                                                  is_legal = 1'b0;
      endcase
   endfunction

   logic op_lw, op_sw, op_br;
   assign op_lw = (opc_q == OP_LW);
   assign op_sw = (opc_q == OP_SW);
   assign op_br = (opc_q == OP_BR);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      case (state_q)
         S_FETCH:  if (MemReady) state_d = S_DECODE;
         S_DECODE: begin
            opc_d   = Opcode;
            state_d = is_legal(Opcode) ? S_EXEC : S_TRAP;
         end
         S_EXEC: begin
            if (op_br)              state_d = S_FETCH;
            else if (op_lw | op_sw) state_d = S_MEM;
            else                    state_d = S_WB;
         end
         S_MEM:    if (MemReady) state_d = op_lw ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_FETCH;
      endcase
   end

   // Output decode: strobes from state (+MemReady where the handshake completes),
   // datapath selects from the latched opcode while an instruction is in flight.
   always_comb begin
      logic dp_on;
      IFetch   = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      ALUSrc   = 1'b0;
      MemtoReg = 1'b0;
      Branch   = 1'b0;
      JSel     = 1'b0;
      JalrSel  = 1'b0;
      RWSel    = 1'b0;
      ALUOp    = 2'b00;
      dp_on    = 1'b0;
      case (state_q)
         S_FETCH: begin
            IFetch  = 1'b1;
            IRWrite = MemReady;
         end
         S_EXEC: begin
            dp_on   = 1'b1;
            PCWrite = op_br;
         end
         S_MEM: begin
            dp_on    = 1'b1;
            MemRead  = op_lw;
            MemWrite = op_sw;
            PCWrite  = op_sw & MemReady;
         end
         S_WB: begin
            dp_on    = 1'b1;
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
         end
         default: ;
      endcase
      if (dp_on) begin
         case (opc_q)
            OP_R:    ALUOp = 2'b10;
            OP_I:    begin ALUOp = 2'b10; ALUSrc = 1'b1; end
            OP_LUI:  begin ALUOp = 2'b11; ALUSrc = 1'b1; end
            OP_LW:   begin ALUOp = 2'b00; ALUSrc = 1'b1; MemtoReg = 1'b1; end
            OP_SW:   begin ALUOp = 2'b00; ALUSrc = 1'b1; end
            OP_BR:   begin ALUOp = 2'b01; Branch = 1'b1; end
            OP_JAL:  begin ALUOp = 2'b00; JSel = 1'b1; RWSel = 1'b1; end
            OP_JALR: begin ALUOp = 2'b00; ALUSrc = 1'b1; JalrSel = 1'b1; RWSel = 1'b1; end
            default: ;
         endcase
      end
   end

   assign State   = state_q;
   assign Illegal = illegal_q;

`ifdef MC_PERF_CNT_EN
   logic [31:0] cyc_q, ret_q;
   assign CycleCnt = cyc_q;
   assign InstRet  = ret_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         opc_q     <= '0;
         illegal_q <= 1'b0;
`ifdef MC_PERF_CNT_EN
         cyc_q     <= '0;
         ret_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         opc_q     <= opc_d;
         illegal_q <= illegal_q | (state_d == S_TRAP);
`ifdef MC_PERF_CNT_EN
         if (state_q != S_TRAP) cyc_q <= cyc_q + 32'd1;
         if (PCWrite)           ret_q <= ret_q + 32'd1;
`endif
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: the driver walks each
// instruction through its phases, pushing the expected per-cycle output vector;
// a negedge monitor pops and compares.

module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] Opcode = '0;
   logic       BrTaken = 1'b0;
   logic       MemReady = 1'b0;
   logic       IFetch, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite;
   logic       MemRead, MemWrite, Branch, JSel, JalrSel, RWSel, Illegal;
   logic [1:0] ALUOp;
   logic [2:0] State;
`ifdef MC_PERF_CNT_EN
   logic [31:0] CycleCnt, InstRet;
`endif

   multicycle_controller dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .BrTaken(BrTaken), .MemReady(MemReady),
      .IFetch(IFetch), .IRWrite(IRWrite), .PCWrite(PCWrite), .ALUSrc(ALUSrc),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .Branch(Branch), .JSel(JSel), .JalrSel(JalrSel), .RWSel(RWSel), .ALUOp(ALUOp),
      .State(State), .Illegal(Illegal)
`ifdef MC_PERF_CNT_EN
      , .CycleCnt(CycleCnt), .InstRet(InstRet)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   logic [6:0] legal_ops [8] = '{OP_I, OP_R, OP_LUI, OP_LW, OP_SW, OP_BR, OP_JALR, OP_JAL};

   typedef struct {
      bit          chk;
      logic [17:0] v;
      int          id;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   instr_id = 0;

   function automatic bit legal(input logic [6:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // {ALUSrc, MemtoReg, Branch, JSel, JalrSel, RWSel, ALUOp[1:0]} from the opcode table
   function automatic logic [7:0] dp_of(input logic [6:0] op);
      case (op)
         OP_R:    return 8'b000000_10;
         OP_I:    return 8'b100000_10;
         OP_LUI:  return 8'b100000_11;
         OP_LW:   return 8'b110000_00;
         OP_SW:   return 8'b100000_00;
         OP_BR:   return 8'b001000_01;
         OP_JAL:  return 8'b000101_00;
         OP_JALR: return 8'b100011_00;
         default: return 8'b0;
      endcase
   endfunction

   // Vector layout: {State, IFetch, IRWrite, PCWrite, RegWrite, MemRead, MemWrite,
   //                 ALUSrc, MemtoReg, Branch, JSel, JalrSel, RWSel, ALUOp, Illegal}
   function automatic logic [17:0] mk(input int st, input bit ifet, input bit irw,
                                      input bit pcw, input bit rw, input bit mrd,
                                      input bit mwr, input logic [6:0] op, input bit ill);
      logic [7:0] dp;
      dp = (st >= 2 && st <= 4) ? dp_of(op) : 8'b0;
      return {st[2:0], ifet, irw, pcw, rw, mrd, mwr, dp, ill};
   endfunction

   function automatic logic [6:0] rnd7();
      return 7'($urandom);
   endfunction

   task automatic cyc(input logic mr, input logic [6:0] opc, input bit rst,
                      input bit chk, input logic [17:0] e);
      reset    = rst;
      MemReady = mr;
      Opcode   = opc;
      BrTaken  = 1'($urandom);
      q.push_back('{chk, e, instr_id});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cyc(1'b0, rnd7(), 1'b1, 1'b0, '0);
      cyc(1'b0, rnd7(), 1'b1, 1'b0, '0);
   endtask

   // One instruction; abort_mem asserts reset on the last MEM wait cycle.
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit abort_mem);
      bit is_lw, is_sw, is_br;
      is_lw = (op == OP_LW);
      is_sw = (op == OP_SW);
      is_br = (op == OP_BR);
      instr_id++;
      for (int i = 0; i < fw; i++) cyc(1'b0, rnd7(), 1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0, 0, op, 0));
      cyc(1'b1, rnd7(), 1'b0, 1'b1, mk(0, 1, 1, 0, 0, 0, 0, op, 0));
      cyc(1'($urandom), op, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, op, 0));
      if (!legal(op)) begin
         for (int i = 0; i < 20; i++)
            cyc(1'($urandom), rnd7(), 1'b0, 1'b1, mk(5, 0, 0, 0, 0, 0, 0, op, 1));
         cyc(1'b0, rnd7(), 1'b1, 1'b1, mk(5, 0, 0, 0, 0, 0, 0, op, 1));
         return;
      end
      cyc(1'($urandom), rnd7(), 1'b0, 1'b1, mk(2, 0, 0, is_br, 0, 0, 0, op, 0));
      if (is_br) return;
      if (is_lw || is_sw) begin
         for (int i = 0; i < mw; i++) begin
            if (abort_mem && i == mw - 1) begin
               cyc(1'b0, rnd7(), 1'b1, 1'b1, mk(3, 0, 0, 0, 0, is_lw, is_sw, op, 0));
               return;
            end
            cyc(1'b0, rnd7(), 1'b0, 1'b1, mk(3, 0, 0, 0, 0, is_lw, is_sw, op, 0));
         end
         cyc(1'b1, rnd7(), 1'b0, 1'b1, mk(3, 0, 0, is_sw, 0, is_lw, is_sw, op, 0));
         if (is_sw) return;
      end
      cyc(1'($urandom), rnd7(), 1'b0, 1'b1, mk(4, 0, 0, 1, 1, 0, 0, op, 0));
   endtask

   // Monitor
   initial begin
      exp_t        e;
      logic [17:0] got;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            got = {State, IFetch, IRWrite, PCWrite, RegWrite, MemRead, MemWrite,
                   ALUSrc, MemtoReg, Branch, JSel, JalrSel, RWSel, ALUOp, Illegal};
            if (e.chk) begin
               vectors++;
               if (got !== e.v) begin
                  miscompares++;
                  $display("FAIL outputs instr=%0d t=%0t got=%b (State=%0d) expected=%b (State=%0d)",
                           e.id, $time, got, got[17:15], e.v, e.v[17:15]);
               end
            end
         end
      end
   end

   // Driver
   initial begin
      logic [6:0] op;
      @(posedge clk);
      #1;
      do_reset();

      // Perf-style run: 10 back-to-back R-type with MemReady tied high
      for (int i = 0; i < 10; i++) run_instr(OP_R, 0, 0, 1'b0);
`ifdef MC_PERF_CNT_EN
      vectors++;
      if (InstRet !== 32'd10) begin
         miscompares++;
         $display("FAIL instret got=%0d expected=10", InstRet);
      end
      vectors++;
      if (CycleCnt !== 32'd40) begin
         miscompares++;
         $display("FAIL cyclecnt got=%0d expected=40", CycleCnt);
      end
`endif

      // Directed cases
      run_instr(OP_LW, 0, 3, 1'b0);       // 8-cycle load
      run_instr(OP_BR, 1, 0, 1'b0);
      run_instr(OP_SW, 2, 2, 1'b0);
      run_instr(OP_SW, 0, 3, 1'b1);       // reset during store wait
      do_reset();
      run_instr(OP_JAL, 1, 0, 1'b0);
      run_instr(7'b1111111, 0, 0, 1'b0);  // illegal -> TRAP, then reset
      run_instr(OP_LUI, 1, 0, 1'b0);      // first fetch cycle after reset

      // Random mix
      for (int n = 0; n < 120; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            do op = rnd7(); while (legal(op));
            run_instr(op, $urandom_range(0, 2), 0, 1'b0);
         end else begin
            op = legal_ops[$urandom_range(0, 7)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0));
         end
      end

      // Drain the scoreboard
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
